// File: rtl/rr_arb_pkg.sv
// Shared constants and state type for the 8-way round-robin burst arbiter.
package rr_arb_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned LEN_W = 4;

    typedef enum logic {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } state_e;

endpackage

// File: rtl/rr8_pick.sv
// Rotating-priority picker: first asserted req bit at or after ptr, wrapping modulo 8.
module rr8_pick (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [7:0] sel,
    output logic [2:0] sel_idx
);

    logic       found;
    logic [2:0] idx;

    always_comb begin
        sel     = '0;
        sel_idx = '0;
        found   = 1'b0;
        idx     = '0;
        // 3-bit addition wraps naturally, giving the modulo-8 scan order.
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                sel[idx]   = 1'b1;
                sel_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/rr8_burst_arbiter.sv
// Round-robin arbiter for 8 requesters; a winner owns the resource for a whole
// burst of req_len+1 accepted beats, with zero-bubble hand-off at burst end.
module rr8_burst_arbiter #(
    parameter int unsigned N     = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N*LEN_W-1:0] req_len,
    input  logic               beat,
    output logic [N-1:0]       gnt,
    output logic [2:0]         gnt_idx,
    output logic               busy,
    output logic               last
);

    import rr_arb_pkg::*;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [2:0]       gnt_idx_q, gnt_idx_d;

    logic             burst_end;
    logic [2:0]       pick_ptr;
    logic [7:0]       pick_sel;
    logic [2:0]       pick_idx;
    logic [LEN_W-1:0] pick_len;

    assign burst_end = (state_q == StOwn) && beat && (cnt_q == '0);
    // At burst end the re-pick must already see the advanced pointer.
    assign pick_ptr  = burst_end ? (gnt_idx_q + 3'd1) : ptr_q;
    assign pick_len  = req_len[int'(pick_idx) * LEN_W +: LEN_W];

    rr8_pick u_pick (
        .req     (req[7:0]),
        .ptr     (pick_ptr),
        .sel     (pick_sel),
        .sel_idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d   = StOwn;
                    gnt_d     = pick_sel;
                    gnt_idx_d = pick_idx;
                    cnt_d     = pick_len;
                end
            end
            StOwn: begin
                if (burst_end) begin
                    ptr_d = gnt_idx_q + 3'd1;
                    if (|req) begin
                        gnt_d     = pick_sel;
                        gnt_idx_d = pick_idx;
                        cnt_d     = pick_len;
                    end else begin
                        state_d   = StIdle;
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                        cnt_d     = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign busy    = (state_q == StOwn);
    assign last    = busy && (cnt_q == '0);

endmodule

// File: tb/tb_rr8_burst_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural owner/remaining-beats model of the arbiter.
module tb_rr8_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req;
    logic [31:0] req_len;
    logic        beat;
    logic [7:0]  gnt;
    logic [2:0]  gnt_idx;
    logic        busy;
    logic        last;

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 when idle), beats still to go, priority pointer.
    int m_owner;
    int m_rem;
    int m_ptr;

    rr8_burst_arbiter #(
        .N     (8),
        .LEN_W (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_len (req_len),
        .beat    (beat),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .last    (last)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic int len_of(input logic [31:0] l, input int i);
        return int'(l[i*4 +: 4]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rem   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_update();
        if (m_owner < 0) begin
            if (req != 8'h00) begin
                m_owner = pick(req, m_ptr);
                m_rem   = len_of(req_len, m_owner) + 1;
            end
        end else if (beat) begin
            m_rem--;
            if (m_rem == 0) begin
                m_ptr = (m_owner + 1) % 8;
                if (req != 8'h00) begin
                    m_owner = pick(req, m_ptr);
                    m_rem   = len_of(req_len, m_owner) + 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [7:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        check("model_gnt", 32'(gnt), 32'(e_gnt));
        check("model_gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("model_busy", 32'(busy), 32'(m_owner >= 0));
        check("model_last", 32'(last), 32'((m_owner >= 0) && (m_rem == 1)));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_model();
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_gnt_idx", 32'(gnt_idx), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [0:6] beat_pat;
        rst_n   = 1'b0;
        req     = 8'h00;
        req_len = 32'h0;
        beat    = 1'b0;
        model_reset();

        // Single requester, 3-beat burst, then pointer observed via next pick.
        do_reset();
        req = 8'h01; req_len = 32'h2; beat = 1'b1;
        tick(); check("t1_gnt", 32'(gnt), 32'h01); check("t1_last0", 32'(last), 32'd0);
        req = 8'h00;
        tick(); check("t1_last1", 32'(last), 32'd0);
        tick(); check("t1_last2", 32'(last), 32'd1);
        tick(); check("t1_idle", 32'(gnt), 32'h00);
        req = 8'h03;
        tick(); check("t1_ptr1", 32'(gnt), 32'h02);

        // Everyone requesting with 1-beat bursts: strict rotation, no bubbles.
        do_reset();
        req = 8'hFF; req_len = 32'h0; beat = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t2_rot", 32'(gnt), 32'(8'h01 << (i % 8)));
            check("t2_last", 32'(last), 32'd1);
        end

        // Owner 3 holds despite dropping req; beats only on beat=1.
        do_reset();
        req = 8'h08; req_len = 32'h3000; beat = 1'b0;
        tick(); check("t3_gnt", 32'(gnt), 32'h08);
        req = 8'h20;
        beat_pat = 7'b1010101;
        for (int i = 0; i < 7; i++) begin
            beat = beat_pat[i];
            tick();
            check("t3_hold", 32'(gnt), (i < 6) ? 32'h08 : 32'h20);
        end

        // Owner 7 finishes: pointer wraps to 0.
        do_reset();
        req = 8'h80; req_len = 32'h0; beat = 1'b1;
        tick(); check("t4_gnt7", 32'(gnt), 32'h80);
        req = 8'h81;
        tick(); check("t4_wrap", 32'(gnt), 32'h01);

        // Reset mid-burst, then arbitration restarts from requester 0.
        do_reset();
        req = 8'h10; req_len = 32'h0005_0000; beat = 1'b1;
        tick(); check("t5_gnt4", 32'(gnt), 32'h10);
        tick(); check("t5_mid", 32'(busy), 32'd1);
        req = 8'h11;
        do_reset();
        tick(); check("t5_restart", 32'(gnt), 32'h01);

        // req_len changes during a burst do not stretch it.
        do_reset();
        req = 8'h04; req_len = 32'h0000_0100; beat = 1'b1;
        tick(); check("t6_gnt2", 32'(gnt), 32'h04);
        req = 8'h00; req_len = 32'h0000_0900;
        tick(); check("t6_beat2", 32'(gnt), 32'h04);
        tick(); check("t6_end", 32'(gnt), 32'h00);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'h00;
            else req = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) req_len = $urandom;
            beat = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
